alu_pipe: RTL and testbench

- Parametrised, handshaked successor to the team's combinational 32-bit ALU.
- Generalises the datapath width.
- Registers the result, adds status flags, and adds ROR, SLT, SLTU and an iterative shift-add MUL.
- Sits between the decode/issue stage and writeback, with valid/ready on both sides so the multicycle MUL can stall issue.

---
 rtl/alu_pipe.sv | 105 ++++++++++
 tb/tb_alu_pipe.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked registered ALU with NZCV flags and fixed-latency shift-add multiply
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);
  typedef enum logic [1:0] {IDLE, MUL_BUSY, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] ma, mb, acc, acc_n, res;
  logic [WIDTH:0] sum, diff;
  logic [SHW-1:0] cnt, sh, r, rn;
  logic c, v, accept, is_mul, last;
  logic [3:0] flags_n;
  assign sh = b[SHW-1:0];
  assign r = alu_op == 4'd10 ? -sh : sh;
  assign rn = -r;
  assign sum = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign in_ready = state == IDLE || (state == DONE && out_ready);
  assign out_valid = state == DONE;
  assign accept = in_valid && in_ready;
  assign is_mul = alu_op == 4'd14;
  assign last = state == MUL_BUSY && cnt == SHW'(WIDTH - 1);
  assign acc_n = mb[0] ? acc + ma : acc;
  assign flags_n = (alu_op == 4'd0 || alu_op == 4'd15) ? 4'b0 : {res[WIDTH-1], res == '0, c, v};
  always_comb begin
    res = '0;
    c = 1'b0;
    v = 1'b0;
    case (alu_op)
      4'd1: begin
        res = sum[WIDTH-1:0];
        c = sum[WIDTH];
        v = a[WIDTH-1] == b[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1];
      end
      4'd2: begin
        res = diff[WIDTH-1:0];
        c = diff[WIDTH];
        v = a[WIDTH-1] != b[WIDTH-1] && diff[WIDTH-1] != a[WIDTH-1];
      end
      4'd3: res = a & b;
      4'd4: res = a | b;
      4'd5: res = a ^ b;
      4'd6: res = ~a;
      4'd7: res = a << sh;
      4'd8: res = a >> sh;
      4'd9: res = $unsigned($signed(a) >>> sh);
      4'd10, 4'd11: res = (a >> r) | (a << rn);
      4'd12: begin
        res = WIDTH'($signed(a) < $signed(b));
        c = diff[WIDTH];
      end
      4'd13: begin
        res = WIDTH'(diff[WIDTH]);
        c = diff[WIDTH];
      end
      default: ;
    endcase
  end
  always_comb begin
    state_n = accept ? (is_mul ? MUL_BUSY : DONE)
            : last ? DONE
            : state == MUL_BUSY ? MUL_BUSY
            : (state == DONE && !out_ready) ? DONE : IDLE;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
      ma <= '0;
      mb <= '0;
      result <= '0;
      flags <= '0;
    end else if (accept && is_mul) begin
      ma <= a;
      mb <= b;
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      result <= res;
      flags <= flags_n;
    end else if (state == MUL_BUSY) begin
      ma <= ma << 1;
      mb <= mb >> 1;
      acc <= acc_n;
      cnt <= cnt + 1'b1;
      if (last) begin
        result <= acc_n;
        flags <= {acc_n[WIDTH-1], acc_n == '0, 2'b00};
      end
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe at WIDTH 32 and WIDTH 8
module tb_alu_pipe;
  logic clk = 0, rst = 1;
  logic in_valid = 0, out_ready = 0, in_ready, out_valid;
  logic [3:0] alu_op = 0, flags;
  logic [31:0] a = 0, b = 0, result;
  logic in_valid8 = 0, out_ready8 = 0, in_ready8, out_valid8;
  logic [3:0] alu_op8 = 0, flags8;
  logic [7:0] a8 = 0, b8 = 0, result8;
  int n_checks = 0, n_fail = 0;
  logic [35:0] q[$];
  logic [35:0] e;
  alu_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .alu_op(alu_op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
  );
  alu_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .alu_op(alu_op8),
    .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8), .result(result8), .flags(flags8)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [35:0] model(logic [3:0] op, logic [31:0] x, logic [31:0] y);
    logic [31:0] rr;
    logic cc, vv;
    int s;
    rr = 0;
    cc = 0;
    vv = 0;
    s = int'(y[4:0]);
    case (op)
      1: begin rr = x + y; cc = rr < x; vv = x[31] == y[31] && rr[31] != x[31]; end
      2: begin rr = x - y; cc = x < y; vv = x[31] != y[31] && rr[31] != x[31]; end
      3: rr = x & y;
      4: rr = x | y;
      5: rr = x ^ y;
      6: rr = ~x;
      7: rr = x << s;
      8: rr = x >> s;
      9: rr = $signed(x) >>> s;
      10: begin rr = x; repeat (s) rr = {rr[30:0], rr[31]}; end
      11: begin rr = x; repeat (s) rr = {rr[0], rr[31:1]}; end
      12: begin rr = {31'b0, $signed(x) < $signed(y)}; cc = x < y; end
      13: begin rr = {31'b0, x < y}; cc = x < y; end
      14: rr = x * y;
      default: rr = 0;
    endcase
    return {rr, (op == 0 || op == 15) ? 4'b0 : {rr[31], rr == 0, cc, vv}};
  endfunction
  function automatic logic [31:0] rnd();
    logic [31:0] edges[4];
    edges = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    return $urandom_range(0, 3) == 0 ? edges[$urandom_range(0, 3)] : $urandom;
  endfunction
  task automatic test_reset;
    rst = 1;
    tick;
    tick;
    rst = 0;
    tick;
    n_checks++;
    if ({out_valid, in_ready, result, flags} !== {1'b0, 1'b1, 32'h0, 4'h0}) begin
      n_fail++;
      $display("FAIL reset: got v=%b r=%b res=%h f=%b, want v=0 r=1 res=0 f=0", out_valid, in_ready, result, flags);
    end
  endtask
  task automatic test_add_sub;
    out_ready = 1;
    in_valid = 1;
    alu_op = 1;
    a = 32'h7FFFFFFF;
    b = 1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL add_in_ready: got %b want 1", in_ready); end
    q.push_back({32'h80000000, 4'b1001});
    tick;
    alu_op = 2;
    a = 5;
    b = 5;
    q.push_back({32'h0, 4'b0100});
    e = q.pop_front();
    n_checks++;
    if ({out_valid, result, flags} !== {1'b1, e}) begin
      n_fail++;
      $display("FAIL add_overflow: got v=%b %h/%b want v=1 %h/%b", out_valid, result, flags, e[35:4], e[3:0]);
    end
    tick;
    in_valid = 0;
    e = q.pop_front();
    n_checks++;
    if ({out_valid, result, flags} !== {1'b1, e}) begin
      n_fail++;
      $display("FAIL sub_zero: got v=%b %h/%b want v=1 %h/%b", out_valid, result, flags, e[35:4], e[3:0]);
    end
    tick;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sub_drain: out_valid got %b want 0", out_valid); end
  endtask
  task automatic test_back_to_back;
    logic [3:0] ops[3];
    logic [31:0] as[3], bs[3], rs[3];
    ops = '{4'd10, 4'd11, 4'd9};
    as = '{32'h80000001, 32'h0000000F, 32'h80000000};
    bs = '{32'd0, 32'd4, 32'd31};
    rs = '{32'h80000001, 32'hF0000000, 32'hFFFFFFFF};
    out_ready = 1;
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      alu_op = ops[i];
      a = as[i];
      b = bs[i];
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready); end
      q.push_back({rs[i], 4'b1000});
      tick;
      e = q.pop_front();
      n_checks++;
      if ({out_valid, result, flags} !== {1'b1, e}) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got v=%b %h/%b want v=1 %h/%b", i, out_valid, result, flags, e[35:4], e[3:0]);
      end
    end
    in_valid = 0;
    tick;
  endtask
  task automatic test_mul;
    out_ready = 1;
    in_valid = 1;
    alu_op = 14;
    a = 32'hFFFFFFFF;
    b = 3;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mul_in_ready: got %b want 1", in_ready); end
    q.push_back({32'hFFFFFFFD, 4'b1000});
    tick;
    in_valid = 0;
    alu_op = 1;
    a = 0;
    b = 0;
    for (int k = 0; k < 32; k++) begin
      n_checks++;
      if ({out_valid, in_ready} !== 2'b00) begin
        n_fail++;
        $display("FAIL mul_busy[%0d]: got v=%b r=%b want v=0 r=0", k, out_valid, in_ready);
      end
      tick;
    end
    e = q.pop_front();
    n_checks++;
    if ({out_valid, result, flags} !== {1'b1, e}) begin
      n_fail++;
      $display("FAIL mul_result: got v=%b %h/%b want v=1 %h/%b", out_valid, result, flags, e[35:4], e[3:0]);
    end
    tick;
  endtask
  task automatic test_backpressure;
    out_ready = 0;
    in_valid = 1;
    alu_op = 12;
    a = 32'hFFFFFFFF;
    b = 1;
    #1;
    q.push_back({32'h1, 4'b0000});
    tick;
    alu_op = 1;
    a = 1;
    b = 1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++;
      if ({out_valid, in_ready, result, flags} !== {1'b1, 1'b0, 32'h1, 4'b0000}) begin
        n_fail++;
        $display("FAIL stall[%0d]: got v=%b r=%b %h/%b want v=1 r=0 00000001/0000", k, out_valid, in_ready, result, flags);
      end
      tick;
    end
    out_ready = 1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release: in_ready got %b want 1", in_ready); end
    e = q.pop_front();
    n_checks++;
    if ({result, flags} !== e) begin n_fail++; $display("FAIL slt: got %h/%b want %h/%b", result, flags, e[35:4], e[3:0]); end
    q.push_back({32'h2, 4'b0000});
    tick;
    in_valid = 0;
    e = q.pop_front();
    n_checks++;
    if ({out_valid, result, flags} !== {1'b1, e}) begin
      n_fail++;
      $display("FAIL after_stall: got v=%b %h/%b want v=1 %h/%b", out_valid, result, flags, e[35:4], e[3:0]);
    end
    tick;
  endtask
  task automatic test_reset_mid_mul;
    out_ready = 1;
    in_valid = 1;
    alu_op = 14;
    a = 32'h1234;
    b = 32'h5678;
    tick;
    in_valid = 0;
    repeat (10) begin
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_mul_valid: got %b want 0", out_valid); end
      tick;
    end
    rst = 1;
    tick;
    rst = 0;
    #1;
    n_checks++;
    if ({out_valid, in_ready, result, flags} !== {1'b1 ^ 1'b1, 1'b1, 32'h0, 4'h0}) begin
      n_fail++;
      $display("FAIL mid_mul_reset: got v=%b r=%b %h/%b want v=0 r=1 0/0", out_valid, in_ready, result, flags);
    end
    in_valid = 1;
    alu_op = 1;
    a = 2;
    b = 3;
    q.push_back({32'h5, 4'b0000});
    tick;
    in_valid = 0;
    e = q.pop_front();
    n_checks++;
    if ({out_valid, result, flags} !== {1'b1, e}) begin
      n_fail++;
      $display("FAIL post_reset_add: got v=%b %h/%b want v=1 %h/%b", out_valid, result, flags, e[35:4], e[3:0]);
    end
    tick;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_drain: got %b want 0", out_valid); end
  endtask
  task automatic test_random;
    int issued, cyc;
    logic hs_in, hs_out;
    issued = 0;
    cyc = 0;
    q.delete();
    alu_op = 4'($urandom_range(0, 15));
    a = rnd();
    b = rnd();
    while ((issued < 40 || q.size() != 0) && cyc < 5000) begin
      in_valid = issued < 40;
      out_ready = $urandom_range(0, 3) != 0;
      #1;
      hs_in = in_valid && in_ready;
      hs_out = out_valid && out_ready;
      if (hs_out) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_extra: got %h/%b with nothing expected", result, flags);
        end else begin
          e = q.pop_front();
          if ({result, flags} !== e) begin
            n_fail++;
            $display("FAIL rand_op: got %h/%b want %h/%b", result, flags, e[35:4], e[3:0]);
          end
        end
      end
      if (hs_in) begin
        q.push_back(model(alu_op, a, b));
        issued++;
      end
      tick;
      cyc++;
      if (hs_in) begin
        alu_op = 4'($urandom_range(0, 15));
        a = rnd();
        b = rnd();
      end
    end
    n_checks++;
    if (issued != 40 || q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_timeout: issued %0d pending %0d want 40 and 0", issued, q.size());
    end
    in_valid = 0;
    out_ready = 1;
    tick;
    tick;
  endtask
  task automatic test_width8;
    out_ready8 = 1;
    in_valid8 = 1;
    alu_op8 = 14;
    a8 = 8'd20;
    b8 = 8'd13;
    #1;
    n_checks++;
    if (in_ready8 !== 1'b1) begin n_fail++; $display("FAIL w8_in_ready: got %b want 1", in_ready8); end
    tick;
    in_valid8 = 0;
    for (int k = 1; k < 8; k++) begin
      tick;
      n_checks++;
      if ({out_valid8, in_ready8} !== 2'b00) begin
        n_fail++;
        $display("FAIL w8_busy[%0d]: got v=%b r=%b want 0 0", k, out_valid8, in_ready8);
      end
    end
    tick;
    n_checks++;
    if ({out_valid8, result8, flags8} !== {1'b1, 8'h04, 4'b0000}) begin
      n_fail++;
      $display("FAIL w8_mul: got v=%b %h/%b want v=1 04/0000", out_valid8, result8, flags8);
    end
    in_valid8 = 1;
    alu_op8 = 7;
    a8 = 8'h01;
    b8 = 8'h0B;
    tick;
    n_checks++;
    if ({out_valid8, result8, flags8} !== {1'b1, 8'h08, 4'b0000}) begin
      n_fail++;
      $display("FAIL w8_sll: got v=%b %h/%b want v=1 08/0000", out_valid8, result8, flags8);
    end
    alu_op8 = 15;
    a8 = 8'hFF;
    b8 = 8'hFF;
    tick;
    in_valid8 = 0;
    n_checks++;
    if ({out_valid8, result8, flags8} !== {1'b1, 8'h00, 4'b0000}) begin
      n_fail++;
      $display("FAIL w8_op15: got v=%b %h/%b want v=1 00/0000", out_valid8, result8, flags8);
    end
    tick;
    n_checks++;
    if (out_valid8 !== 1'b0) begin n_fail++; $display("FAIL w8_drain: got %b want 0", out_valid8); end
  endtask
  initial begin
    test_reset;
    test_add_sub;
    test_back_to_back;
    test_mul;
    test_backpressure;
    test_reset_mid_mul;
    test_random;
    test_width8;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
